mont_const_gen: RTL and testbench

- Sequential generator of Montgomery domain constants for the Paillier/RSA datapath.
- Given an odd modulus n, it produces:
  - R mod n, where R = 2^WIDTH
  - R^2 mod n
  - n' = -n^-1 mod 2^NPRIME_W
- Uses bit-serial shift-subtract instead of a combinational `%` operator.
- Feeds the Montgomery multiplier with its precomputed constants. Has a start/done handshake, mode select, abort and input error detection.

---
 rtl/mont_const_gen_if.sv | 27 ++
 rtl/mont_const_gen.sv | 130 +++++++++++++
 tb/tb_mont_const_gen.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_const_gen_if.sv
// Start/done handshake and result bus between a Montgomery constant generator and its consumer.
// The master drives the request; the slave returns the constants and completion status.
interface mont_const_gen_if #(
    parameter int WIDTH    = 4096,
    parameter int NPRIME_W = 64
);
    logic                start;
    logic                mode;
    logic                abort;
    logic [WIDTH-1:0]    n;
    logic                ready;
    logic                done;
    logic                err;
    logic [WIDTH-1:0]    r_mod;
    logic [WIDTH-1:0]    r2_mod;
    logic [NPRIME_W-1:0] n_prime;

    modport master (
        output start, mode, abort, n,
        input  ready, done, err, r_mod, r2_mod, n_prime
    );

    modport slave (
        input  start, mode, abort, n,
        output ready, done, err, r_mod, r2_mod, n_prime
    );
endinterface

// File: rtl/mont_const_gen.sv
// Montgomery constants for odd n: R mod n, R^2 mod n (mode 1), n' = -n^-1 mod 2^NPRIME_W.
// Latency WIDTH+2 / 2*WIDTH+2 cycles (2 when n invalid); start taken only while ready, outputs never stall.
module mont_const_gen #(
    parameter int WIDTH    = 4096,
    parameter int NPRIME_W = 64,
    parameter int CNT_W    = $clog2(2*WIDTH+1)
) (
    input  logic            clk,
    input  logic            rst_n,
    mont_const_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, DOUBLE, FIN} state_t;

    localparam logic [CNT_W-1:0]    STEP_R      = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]    STEP_R2     = CNT_W'(2*WIDTH);
    localparam logic [CNT_W-1:0]    HENSEL_LAST = CNT_W'(NPRIME_W-1);
    localparam logic [NPRIME_W-1:0] NP_ONE      = NPRIME_W'(1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    n_q;
    logic                mode_q;
    logic [WIDTH-1:0]    x_q, x_nxt;
    logic [NPRIME_W-1:0] y_q, y_nxt, prod;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [WIDTH:0]      t, t_sub;
    logic                t_ge_n, n_bad, at_r, at_r2, hensel_flip;
    logic                err_q;
    logic [WIDTH-1:0]    r_mod_q, r2_mod_q;
    logic [NPRIME_W-1:0] n_prime_q;
    logic                unused_sub_msb;

    // Doubling step: x stays reduced below n, so the difference always fits WIDTH bits.
    assign t              = {x_q, 1'b0};
    assign t_sub          = t - {1'b0, n_q};
    assign t_ge_n         = (t >= {1'b0, n_q});
    assign x_nxt          = t_ge_n ? t_sub[WIDTH-1:0] : t[WIDTH-1:0];
    assign unused_sub_msb = t_sub[WIDTH];

    assign cnt_nxt = cnt_q + 1'b1;
    assign at_r    = (cnt_nxt == STEP_R);
    assign at_r2   = (cnt_nxt == STEP_R2);
    assign n_bad   = !n_q[0] || (n_q < WIDTH'(3));

    // Hensel lift: y is n^-1 mod 2^i before step i; flipping bit i fixes bit i of n*y.
    assign prod        = n_q[NPRIME_W-1:0] * y_q;
    assign hensel_flip = (cnt_nxt <= HENSEL_LAST) && |(prod & (NP_ONE << cnt_nxt));
    assign y_nxt       = hensel_flip ? (y_q + (NP_ONE << cnt_nxt)) : y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = CHECK;
                CHECK:   state_d = n_bad ? FIN : DOUBLE;
                DOUBLE:  if ((at_r && !mode_q) || at_r2) state_d = FIN;
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= '0;
            mode_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= NP_ONE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            r_mod_q   <= '0;
            r2_mod_q  <= '0;
            n_prime_q <= '0;
        end else if (!bus.abort) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        n_q    <= bus.n;
                        mode_q <= bus.mode;
                        x_q    <= WIDTH'(1);
                        y_q    <= NP_ONE;
                        cnt_q  <= '0;
                    end
                end
                CHECK: begin
                    if (n_bad) begin
                        err_q     <= 1'b1;
                        r_mod_q   <= '0;
                        r2_mod_q  <= '0;
                        n_prime_q <= '0;
                    end
                end
                DOUBLE: begin
                    x_q   <= x_nxt;
                    y_q   <= y_nxt;
                    cnt_q <= cnt_nxt;
                    if (at_r) begin
                        r_mod_q   <= x_nxt;
                        n_prime_q <= ~y_q + 1'b1;
                        if (!mode_q) begin
                            r2_mod_q <= '0;
                            err_q    <= 1'b0;
                        end
                    end
                    if (at_r2) begin
                        r2_mod_q <= x_nxt;
                        err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = (state_q == IDLE);
    assign bus.done    = (state_q == FIN);
    assign bus.err     = err_q;
    assign bus.r_mod   = r_mod_q;
    assign bus.r2_mod  = r2_mod_q;
    assign bus.n_prime = n_prime_q;
endmodule

// File: tb/tb_mont_const_gen.sv
// Directed and randomised checks of mont_const_gen at WIDTH=8/NPRIME_W=8 and WIDTH=64/NPRIME_W=32
// against a plain-arithmetic reference (modulo by wide division, inverse by Newton iteration).
module tb_mont_const_gen;
    localparam int W8   = 8;
    localparam int NP8  = 8;
    localparam int W64  = 64;
    localparam int NP64 = 32;

    typedef struct {
        logic [63:0] n;
        bit          mode;
        bit          err;
        logic [63:0] r;
        logic [63:0] r2;
        logic [63:0] np;
        int          acc;
    } job_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   accepted8 = 0, done8 = 0, cancelled8 = 0;
    int   accepted64 = 0, done64 = 0;
    job_t q8[$];
    job_t q64[$];
    int   acc8_hist[$];
    logic [63:0] held_r = '0, held_r2 = '0, held_np = '0;
    logic        held_err = 1'b0;

    always #5 clk = ~clk;

    mont_const_gen_if #(.WIDTH(W8),  .NPRIME_W(NP8))  b8  ();
    mont_const_gen_if #(.WIDTH(W64), .NPRIME_W(NP64)) b64 ();

    mont_const_gen #(.WIDTH(W8), .NPRIME_W(NP8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    mont_const_gen #(.WIDTH(W64), .NPRIME_W(NP64)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b64)
    );

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    // Reference: R and R^2 reduced by direct wide division; inverse by Newton (y <- y*(2-n*y)).
    function automatic job_t make_job(logic [63:0] nv, int w, int np, bit m, int acc);
        job_t        j;
        logic [129:0] big;
        logic [63:0]  y, mask;
        j.n    = nv;
        j.mode = m;
        j.acc  = acc;
        j.err  = (nv[0] == 1'b0) || (nv < 64'd3);
        mask   = (np >= 64) ? '1 : ((64'd1 << np) - 64'd1);
        if (j.err) begin
            j.r  = '0;
            j.r2 = '0;
            j.np = '0;
        end else begin
            big  = 130'd1 << w;
            j.r  = 64'(big % 130'(nv));
            big  = 130'd1 << (2*w);
            j.r2 = m ? 64'(big % 130'(nv)) : 64'd0;
            y    = nv;
            repeat (6) y = y * (64'd2 - nv * y);
            j.np = (~y + 64'd1) & mask;
        end
        return j;
    endfunction

    function automatic void check_job(string tag, job_t j, int lat, int w,
                                      logic [63:0] r, logic [63:0] r2, logic [63:0] np, logic e);
        int exp_lat;
        exp_lat = j.err ? 2 : (j.mode ? 2*w + 2 : w + 2);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_err"},     64'(e),   64'(j.err));
        chk({tag, "_r_mod"},   r,        j.r);
        chk({tag, "_r2_mod"},  r2,       j.r2);
        chk({tag, "_n_prime"}, np,       j.np);
    endfunction

    // Job acceptance, abort bookkeeping and reset flush, sampled on the active edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            cancelled8 += q8.size();
            q8.delete();
            q64.delete();
            held_r   = '0;
            held_r2  = '0;
            held_np  = '0;
            held_err = 1'b0;
        end else begin
            if (b8.abort && q8.size() > 0) begin
                if (!q8[0].err && (cyc - q8[0].acc) > W8 + 1) begin
                    held_r  = q8[0].r;
                    held_np = q8[0].np;
                    if (!q8[0].mode) held_r2 = '0;
                end
                q8.delete(0);
                cancelled8++;
            end else if (b8.ready && b8.start && !b8.abort) begin
                q8.push_back(make_job(64'(b8.n), W8, NP8, b8.mode, cyc));
                acc8_hist.push_back(cyc);
                accepted8++;
            end
            if (b64.ready && b64.start && !b64.abort) begin
                q64.push_back(make_job(b64.n, W64, NP64, b64.mode, cyc));
                accepted64++;
            end
        end
        cyc++;
    end

    // Output comparison on every cycle, away from the active edge.
    always @(negedge clk) begin
        job_t j;
        if (rst_n) begin
            chk("ready8_vs_pending", 64'(b8.ready), 64'(q8.size() == 0));
            if (b8.ready) begin
                chk("hold8_r_mod",   64'(b8.r_mod),   held_r);
                chk("hold8_r2_mod",  64'(b8.r2_mod),  held_r2);
                chk("hold8_n_prime", 64'(b8.n_prime), held_np);
                chk("hold8_err",     64'(b8.err),     64'(held_err));
            end
            if (b8.done) begin
                if (q8.size() == 0) begin
                    chk("spurious_done8", 64'(b8.done), 64'd0);
                end else begin
                    j = q8.pop_front();
                    check_job("job8", j, cyc - j.acc, W8, 64'(b8.r_mod), 64'(b8.r2_mod),
                              64'(b8.n_prime), b8.err);
                    held_r   = j.r;
                    held_r2  = j.r2;
                    held_np  = j.np;
                    held_err = j.err;
                    done8++;
                end
            end
            if (b64.done) begin
                if (q64.size() == 0) begin
                    chk("spurious_done64", 64'(b64.done), 64'd0);
                end else begin
                    j = q64.pop_front();
                    check_job("job64", j, cyc - j.acc, W64, b64.r_mod, b64.r2_mod,
                              64'(b64.n_prime), b64.err);
                    done64++;
                end
            end
        end
    end

    task automatic wait_idle8(int budget);
        int i;
        i = 0;
        while (!(b8.ready && q8.size() == 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("idle8_timeout", 64'(b8.ready && q8.size() == 0), 64'd1);
    endtask

    task automatic wait_idle64(int budget);
        int i;
        i = 0;
        while (!(b64.ready && q64.size() == 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("idle64_timeout", 64'(b64.ready && q64.size() == 0), 64'd1);
    endtask

    task automatic kick8(logic [7:0] nv, bit m);
        @(negedge clk);
        b8.n = nv; b8.mode = m; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        b8.n     = ~nv;
    endtask

    task automatic run8(logic [7:0] nv, bit m);
        kick8(nv, m);
        wait_idle8(2*W8 + 10);
    endtask

    task automatic run64(logic [63:0] nv, bit m);
        @(negedge clk);
        b64.n = nv; b64.mode = m; b64.start = 1'b1;
        @(negedge clk);
        b64.start = 1'b0;
        b64.n     = ~nv;
        wait_idle64(2*W64 + 10);
    endtask

    task automatic expect8(string tag, logic [63:0] r, logic [63:0] r2, logic [63:0] np, logic e);
        chk({tag, "_r_mod"},   64'(b8.r_mod),   r);
        chk({tag, "_r2_mod"},  64'(b8.r2_mod),  r2);
        chk({tag, "_n_prime"}, 64'(b8.n_prime), np);
        chk({tag, "_err"},     64'(b8.err),     64'(e));
    endtask

    initial begin
        job_t        j;
        int          base;
        logic [63:0] nv;
        logic [31:0] pr;

        b8.start = 1'b0;  b8.mode = 1'b0;  b8.abort = 1'b0;  b8.n = '0;
        b64.start = 1'b0; b64.mode = 1'b0; b64.abort = 1'b0; b64.n = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Pin the reference: 13*59 = 767 = -1 mod 256; 251*205 = 51455 = -1 mod 256.
        j = make_job(64'd13, 8, 8, 1'b1, 0);
        chk("model_13_r", j.r, 64'd9);  chk("model_13_r2", j.r2, 64'd3);  chk("model_13_np", j.np, 64'd59);
        j = make_job(64'd251, 8, 8, 1'b0, 0);
        chk("model_251_r", j.r, 64'd5); chk("model_251_r2", j.r2, 64'd0); chk("model_251_np", j.np, 64'd205);
        j = make_job(64'd12, 8, 8, 1'b1, 0);
        chk("model_12_err", 64'(j.err), 64'd1);

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(b8.ready), 64'd1);
        chk("rst_done",  64'(b8.done),  64'd0);
        expect8("rst", 64'd0, 64'd0, 64'd0, 1'b0);
        chk("rst_ready64", 64'(b64.ready), 64'd1);
        chk("rst_r_mod64", b64.r_mod, 64'd0);
        rst_n = 1'b1;

        run8(8'd13, 1'b1);  expect8("n13", 64'd9, 64'd3, 64'd59, 1'b0);
        run8(8'd251, 1'b0); expect8("n251", 64'd5, 64'd0, 64'd205, 1'b0);
        run8(8'd255, 1'b1); expect8("n255", 64'd1, 64'd1, 64'd1, 1'b0);
        run8(8'd12, 1'b1);  expect8("n12", 64'd0, 64'd0, 64'd0, 1'b1);
        run8(8'd1, 1'b0);   expect8("n1", 64'd0, 64'd0, 64'd0, 1'b1);

        // Abort 12 cycles into a mode-1 job: R mod n and n' are already captured.
        kick8(8'd13, 1'b1);
        repeat (11) @(negedge clk);
        b8.abort = 1'b1;
        @(negedge clk);
        b8.abort = 1'b0;
        chk("abort_ready", 64'(b8.ready), 64'd1);
        chk("abort_r_mod", 64'(b8.r_mod), 64'd9);
        chk("abort_n_prime", 64'(b8.n_prime), 64'd59);
        run8(8'd251, 1'b0); expect8("post_abort", 64'd5, 64'd0, 64'd205, 1'b0);

        // start held high: back-to-back jobs separated by a single ready cycle.
        base = accepted8;
        @(negedge clk);
        b8.n = 8'd13; b8.mode = 1'b0; b8.start = 1'b1;
        for (int i = 0; i < 40 && accepted8 < base + 2; i++) @(negedge clk);
        b8.start = 1'b0;
        chk("b2b_jobs", 64'(accepted8 - base), 64'd2);
        if (acc8_hist.size() >= 2)
            chk("b2b_gap", 64'(acc8_hist[acc8_hist.size()-1] - acc8_hist[acc8_hist.size()-2]), 64'(W8 + 3));
        wait_idle8(30);

        // start while busy is ignored; the first job's results stand.
        base = accepted8;
        kick8(8'd13, 1'b1);
        repeat (3) @(negedge clk);
        b8.n = 8'd255; b8.mode = 1'b0; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        wait_idle8(40);
        chk("busy_start_ignored", 64'(accepted8 - base), 64'd1);
        expect8("busy", 64'd9, 64'd3, 64'd59, 1'b0);

        // abort and start together in IDLE: nothing is accepted.
        base = accepted8;
        @(negedge clk);
        b8.n = 8'd251; b8.mode = 1'b0; b8.start = 1'b1; b8.abort = 1'b1;
        @(negedge clk);
        b8.start = 1'b0; b8.abort = 1'b0;
        chk("abort_start_ready", 64'(b8.ready), 64'd1);
        chk("abort_start_dropped", 64'(accepted8 - base), 64'd0);

        // Reset while doubling, after r_mod was captured, clears everything at once.
        kick8(8'd13, 1'b1);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(b8.ready), 64'd1);
        chk("midrst_done",  64'(b8.done),  64'd0);
        expect8("midrst", 64'd0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'd251, 1'b0); expect8("post_rst", 64'd5, 64'd0, 64'd205, 1'b0);

        // Wide configuration: random odd moduli plus edge values.
        for (int k = 0; k < 8; k++) begin
            nv = {$urandom(), $urandom()} | 64'd1;
            if (k == 0) nv = 64'hFFFF_FFFF_FFFF_FFFF;
            if (k == 1) nv = 64'd3;
            if (k == 7) nv = nv & ~64'd1;
            run64(nv, k[0]);
            if (nv[0] && nv >= 64'd3) begin
                pr = nv[31:0] * b64.n_prime;
                chk("np64_identity", 64'(pr), 64'h0000_0000_FFFF_FFFF);
            end
        end

        chk("jobs8_accounted",  64'(accepted8),  64'(done8 + cancelled8));
        chk("jobs64_accounted", 64'(accepted64), 64'(done64));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
